// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core: opcodes, funct codes,
// FSM states and ALU control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_ctl_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 hard-wired to zero, contents cleared by reset.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_mips.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with handshaked
// instruction and data memories and a sticky, absorbing trap state.
module multicycle_mips import mips_pkg::*; #(
  parameter int          DMEM_AW      = 7,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        IR_addr,
  output logic               IR_req,
  input  logic [31:0]        IR,
  input  logic               IR_valid,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [31:0]        Data2Mem,
  input  logic [31:0]        ReadDataMem,
  input  logic               MemValid,
  output logic               trap
);

  state_t             state, next_state;
  logic [31:0]        pc, pc_d, pc_plus4, ir, alu_out, mdr, alu_res;
  logic signed [31:0] a_r, b_r, imm_r, op_b;
  logic [15:0]        wait_cnt;
  logic               pc_ld, waiting, wait_hit, ea_bad, taken;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata, rf_rd1, rf_rd2;
  logic               legal, use_imm, zero_ext;
  logic               is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
  alu_ctl_t           alu_ctl;

  wire [5:0] opcode = ir[31:26];
  wire [4:0] rs     = ir[25:21];
  wire [4:0] rt     = ir[20:16];
  wire [4:0] rd     = ir[15:11];
  wire [4:0] shamt  = ir[10:6];
  wire [5:0] funct  = ir[5:0];

  mips_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  always_comb begin
    legal = 1'b1; alu_ctl = ALU_ADD; use_imm = 1'b0; zero_ext = 1'b0;
    is_r = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0;
    is_bne = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          FN_SLL:  alu_ctl = ALU_SLL;
          FN_SRL:  alu_ctl = ALU_SRL;
          FN_JR:   begin is_r = 1'b0; is_jr = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: use_imm = 1'b1;
      OP_SLTI: begin use_imm = 1'b1; alu_ctl = ALU_SLT; end
      OP_ANDI: begin use_imm = 1'b1; zero_ext = 1'b1; alu_ctl = ALU_AND; end
      OP_ORI:  begin use_imm = 1'b1; zero_ext = 1'b1; alu_ctl = ALU_OR; end
      OP_LW:   begin use_imm = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    op_b = use_imm ? (zero_ext ? {16'h0000, ir[15:0]} : imm_r) : b_r;
    case (alu_ctl)
      ALU_SUB: alu_res = a_r - op_b;
      ALU_AND: alu_res = a_r & op_b;
      ALU_OR:  alu_res = a_r | op_b;
      ALU_SLT: alu_res = (a_r < op_b) ? 32'd1 : 32'd0;
      ALU_SLL: alu_res = b_r << shamt;
      ALU_SRL: alu_res = b_r >> shamt;
      default: alu_res = a_r + op_b;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign taken    = (is_beq && a_r == b_r) || (is_bne && a_r != b_r);
  // Data memory only covers word-aligned addresses inside its window.
  assign ea_bad   = (alu_res[1:0] != 2'b00) || ((alu_res >> (DMEM_AW + 2)) != 32'd0);
  assign waiting  = (state == FETCH && IR_req) || state == MEM;
  assign wait_hit = (wait_cnt == 16'(MEM_WAIT_MAX - 1));

  always_comb begin
    next_state = state;
    pc_ld = 1'b0; pc_d = pc_plus4;
    rf_we = 1'b0; rf_waddr = is_r ? rd : rt; rf_wdata = is_lw ? mdr : alu_out;
    case (state)
      FETCH: begin
        if (IR_req && IR_valid) next_state = DECODE;
        else if (IR_req && wait_hit) next_state = TRAP;
      end
      DECODE: next_state = legal ? EXEC : TRAP;
      EXEC: begin
        if (is_beq || is_bne || is_j || is_jal || is_jr) begin
          pc_ld = 1'b1;
          next_state = FETCH;
          if (taken) pc_d = pc_plus4 + {imm_r[29:0], 2'b00};
          else if (is_j || is_jal) pc_d = {pc_plus4[31:28], ir[25:0], 2'b00};
          else if (is_jr) pc_d = a_r;
          if (is_jal) begin rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = pc_plus4; end
        end else if (is_lw || is_sw) begin
          next_state = ea_bad ? TRAP : MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        if (MemValid) begin
          next_state = is_sw ? FETCH : WB;
          pc_ld = is_sw;
        end else if (wait_hit) begin
          next_state = TRAP;
        end
      end
      WB: begin
        rf_we = 1'b1;
        pc_ld = 1'b1;
        next_state = FETCH;
      end
      default: next_state = TRAP;
    endcase
  end

  // Memory-side strobes are registered from next_state so they are glitch-free
  // and can be forced inactive directly by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      wait_cnt <= '0;
      IR_req   <= 1'b0;
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= '0;
    end else begin
      state <= next_state;
      if (pc_ld) pc <= pc_d;
      if (next_state != state) wait_cnt <= '0;
      else if (waiting) wait_cnt <= wait_cnt + 16'd1;
      IR_req <= (next_state == FETCH);
      CEN    <= (next_state != MEM);
      WEN    <= !(next_state == MEM && is_sw);
      OEN    <= !(next_state == MEM && is_lw);
      if (state == EXEC && next_state == MEM) begin
        A        <= alu_res[DMEM_AW+1:2];
        Data2Mem <= b_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == FETCH && IR_req && IR_valid) ir <= IR;
    if (state == DECODE) begin
      a_r   <= rf_rd1;
      b_r   <= rf_rd2;
      imm_r <= {{16{ir[15]}}, ir[15:0]};
    end
    if (state == EXEC) alu_out <= alu_res;
    if (state == MEM && MemValid) mdr <= ReadDataMem;
  end

  assign IR_addr = pc;
  assign trap    = (state == TRAP);

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: drives instruction and data memory
// handshakes step by step and checks bus activity against hand-computed values.
module tb_multicycle_mips;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] IR_addr, IR, Data2Mem, ReadDataMem;
  logic        IR_req, IR_valid, CEN, WEN, OEN, MemValid, trap;
  logic [6:0]  A;
  int          checks = 0;
  int          failures = 0;

  multicycle_mips dut (
    .clk         (clk),
    .rst         (rst),
    .IR_addr     (IR_addr),
    .IR_req      (IR_req),
    .IR          (IR),
    .IR_valid    (IR_valid),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem),
    .MemValid    (MemValid),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] exp_pc, input logic [31:0] instr);
    int n = 0;
    while (IR_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_req"}, 32'(IR_req), 32'd1);
    chk({tag, "_pc"}, IR_addr, exp_pc);
    IR = instr;
    IR_valid = 1'b1;
    @(negedge clk);
    IR_valid = 1'b0;
  endtask

  task automatic mem(input string tag, input bit store, input int delay,
                     input logic [6:0] exp_a, input logic [31:0] exp_d,
                     input logic [31:0] rdata);
    int n = 0;
    int low = 0;
    while (CEN !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_cen"}, 32'(CEN), 32'd0);
    chk({tag, "_a"}, 32'(A), 32'(exp_a));
    if (store) chk({tag, "_d"}, Data2Mem, exp_d);
    for (int k = 0; k <= delay; k++) begin
      if (CEN === 1'b0 && A === exp_a &&
          (store ? (WEN === 1'b0 && OEN === 1'b1) : (OEN === 1'b0 && WEN === 1'b1)))
        low++;
      if (k == delay) begin
        MemValid = 1'b1;
        ReadDataMem = rdata;
      end
      @(negedge clk);
    end
    MemValid = 1'b0;
    chk({tag, "_strobe_cycles"}, 32'(low), 32'(delay + 1));
    chk({tag, "_released"}, {29'd0, CEN, WEN, OEN}, 32'd7);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int low;
    IR = '0; IR_valid = 1'b0; MemValid = 1'b0; ReadDataMem = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {28'd0, IR_req, CEN, WEN, OEN}, 32'd7);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_a", 32'(A), 32'd0);
    chk("rst_d2m", Data2Mem, 32'd0);
    chk("rst_pc", IR_addr, 32'd0);
    rst = 1'b0;

    fetch("addi_r1", 32'h00, 32'h2001_0005);
    fetch("addi_r2", 32'h04, 32'h2002_FFFD);
    fetch("add_r3", 32'h08, 32'h0022_1820);
    fetch("sw_r3", 32'h0C, 32'hAC03_0004);
    mem("sw_r3", 1'b1, 0, 7'd1, 32'd2, 32'd0);
    fetch("beq_eq", 32'h10, 32'h1021_FFFF);
    fetch("bne_eq", 32'h10, 32'h1421_FFFF);
    fetch("sw_r1", 32'h14, 32'hAC01_0008);
    mem("sw_r1", 1'b1, 3, 7'd2, 32'd5, 32'd0);
    fetch("lw_r4", 32'h18, 32'h8C04_0008);
    mem("lw_r4", 1'b0, 1, 7'd2, 32'd0, 32'd5);
    fetch("sw_r4", 32'h1C, 32'hAC04_000C);
    mem("sw_r4", 1'b1, 0, 7'd3, 32'd5, 32'd0);
    fetch("jal", 32'h20, 32'h0C00_0040);
    fetch("jr_r31", 32'h100, 32'h03E0_0008);

    fetch("sub", 32'h24, 32'h0041_2822);
    fetch("slt", 32'h28, 32'h00A1_302A);
    fetch("andi", 32'h2C, 32'h30A7_FFFF);
    fetch("sll", 32'h30, 32'h0007_4100);
    fetch("addi_r0", 32'h34, 32'h2000_0007);
    fetch("ori", 32'h38, 32'h3409_8001);
    fetch("srl", 32'h3C, 32'h0005_5702);
    fetch("slti", 32'h40, 32'h28AB_0001);
    fetch("or", 32'h44, 32'h00E9_6025);
    fetch("and", 32'h48, 32'h00A9_6824);
    fetch("sw_sub", 32'h4C, 32'hAC05_0010);
    mem("sw_sub", 1'b1, 0, 7'd4, 32'hFFFF_FFF8, 32'd0);
    fetch("sw_slt", 32'h50, 32'hAC06_0014);
    mem("sw_slt", 1'b1, 0, 7'd5, 32'd1, 32'd0);
    fetch("sw_sll", 32'h54, 32'hAC08_0018);
    mem("sw_sll", 1'b1, 0, 7'd6, 32'h000F_FF80, 32'd0);
    fetch("sw_r0", 32'h58, 32'hAC00_001C);
    mem("sw_r0", 1'b1, 0, 7'd7, 32'd0, 32'd0);
    fetch("sw_srl", 32'h5C, 32'hAC0A_0020);
    mem("sw_srl", 1'b1, 0, 7'd8, 32'h0000_000F, 32'd0);
    fetch("sw_slti", 32'h60, 32'hAC0B_0024);
    mem("sw_slti", 1'b1, 0, 7'd9, 32'd1, 32'd0);
    fetch("sw_or", 32'h64, 32'hAC0C_0028);
    mem("sw_or", 1'b1, 0, 7'd10, 32'h0000_FFF9, 32'd0);
    fetch("sw_and", 32'h68, 32'hAC0D_002C);
    mem("sw_and", 1'b1, 0, 7'd11, 32'h0000_8000, 32'd0);
    fetch("j", 32'h6C, 32'h0800_0060);

    // Misaligned load must trap without touching the data memory.
    fetch("lw_misalign", 32'h180, 32'h8C04_0006);
    low = 0;
    for (int k = 0; k < 6; k++) begin
      if (CEN === 1'b0) low++;
      @(negedge clk);
    end
    chk("misalign_cen_cycles", 32'(low), 32'd0);
    chk("misalign_trap", 32'(trap), 32'd1);
    chk("misalign_strobes", {28'd0, IR_req, CEN, WEN, OEN}, 32'd7);

    // Store with no MemValid: times out after 15 cycles; r1 cleared by reset.
    do_reset();
    chk("post_rst_trap", 32'(trap), 32'd0);
    fetch("sw_timeout", 32'h00, 32'hAC01_0000);
    n = 0;
    while (CEN !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("timeout_cen", 32'(CEN), 32'd0);
    chk("timeout_d2m_cleared", Data2Mem, 32'd0);
    low = 0;
    while (CEN === 1'b0 && low < 40) begin low++; @(negedge clk); end
    chk("timeout_cycles", 32'(low), 32'd15);
    chk("timeout_trap", 32'(trap), 32'd1);

    // Asynchronous reset in the middle of a store.
    do_reset();
    fetch("sw_rst", 32'h00, 32'hAC00_0004);
    n = 0;
    while (CEN !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("midmem_cen_low", 32'(CEN), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midmem_cen_async", 32'(CEN), 32'd1);
    chk("midmem_wen_async", 32'(WEN), 32'd1);
    chk("midmem_a_async", 32'(A), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midmem_req_held", 32'(IR_req), 32'd0);
    @(posedge clk);
    #1;
    chk("midmem_req_rise", 32'(IR_req), 32'd1);
    chk("midmem_refetch_pc", IR_addr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_mips.md
MULTICYCLE_MIPS -- requirements
Module: multicycle_mips

Interface
REQ-001 SHALL have parameter DMEM_AW, default 7, data-memory word-address width (A width).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 SHALL have parameter MEM_WAIT_MAX, default 15, maximum cycles to wait for a memory handshake before trap.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port IR_addr  out  32  byte address of the instruction being fetched.
REQ-007 Port IR_req  out  1  fetch request, held high until IR_valid.
REQ-008 Port IR  in  32  instruction word, valid when IR_valid=1.
REQ-009 Port IR_valid  in  1  instruction-memory response strobe.
REQ-010 Port CEN  out  1  data-memory chip enable, active-low.
REQ-011 Port WEN  out  1  data-memory write enable, active-low.
REQ-012 Port OEN  out  1  data-memory output enable, active-low.
REQ-013 Port A  out  DMEM_AW  data-memory word address, ALU_result[DMEM_AW+1:2].
REQ-014 Port Data2Mem  out  32  store data (rt).
REQ-015 Port ReadDataMem  in  32  load data, valid when MemValid=1.
REQ-016 Port MemValid  in  1  data-memory completion strobe for read or write.
REQ-017 Port trap  out  1  sticky error flag (illegal instruction, misaligned access or memory timeout).

Function
REQ-018 SHALL implement an FSM with states FETCH, DECODE, EXEC, MEM, WB and TRAP; one instruction completes per pass through the FSM.
REQ-019 FETCH SHALL drive IR_addr=PC and IR_req=1, latch IR into an internal IR register on IR_valid=1, then go to DECODE.
REQ-020 DECODE SHALL read rs/rt from the register file into registers A_r/B_r and latch sign-extended imm16; an illegal opcode or funct SHALL go to TRAP.
REQ-021 Supported instructions: add, sub, and, or, slt, sll, srl, jr (R-type); addi, andi (zero-extended), ori (zero-extended), slti, lw, sw, beq, bne, j, jal.
REQ-022 EXEC SHALL compute the ALU result (32-bit wrap, no overflow trap). beq/bne/j/jal/jr SHALL update PC and return to FETCH. R/I ALU ops SHALL go to WB. lw/sw SHALL go to MEM.
REQ-023 Branch target SHALL be PC+4+(simm16<<2); jump target SHALL be {PC+4[31:28], addr26, 2'b00}; jal SHALL write PC+4 to r31 in EXEC.
REQ-024 MEM SHALL assert CEN=0 and either (OEN=0, WEN=1) for lw or (WEN=0, OEN=1) for sw, holding A and Data2Mem stable until MemValid=1.
REQ-025 On MemValid=1, lw SHALL latch ReadDataMem and go to WB; sw SHALL set PC=PC+4 and go to FETCH.
REQ-026 If an effective address has bits[1:0]!=0, or bits[31:DMEM_AW+2]!=0, the FSM SHALL go to TRAP without asserting CEN.
REQ-027 A wait counter SHALL count cycles in FETCH and MEM without a response; reaching MEM_WAIT_MAX SHALL go to TRAP.
REQ-028 WB SHALL write rd (R-type) or rt (I-type, lw), set PC=PC+4, and go to FETCH.
REQ-029 Writes to r0 SHALL be discarded; r0 SHALL always read 0.
REQ-030 TRAP SHALL be absorbing: trap=1, IR_req=0, CEN=WEN=OEN=1; only reset exits.
REQ-031 Outside MEM, CEN, WEN and OEN SHALL be 1. Outside FETCH, IR_req SHALL be 0.
REQ-032 A response strobe arriving in a state that does not expect it SHALL be ignored.

Reset
REQ-033 rst=1 SHALL immediately force: state=FETCH, PC=RESET_PC, trap=0, wait counter=0, CEN=WEN=OEN=1, IR_req=0, A=0, Data2Mem=0.
REQ-034 Register-file contents SHALL be cleared to 0 by reset.
REQ-035 Reset asserted mid-MEM SHALL drop CEN in the same cycle; IR_req SHALL rise on the first clock edge after rst deasserts.

Structure
REQ-036 A package mips_pkg SHALL hold the opcode and funct constants, the FSM state enum and the ALU-control encodings.
REQ-037 The register file SHALL be a sub-module mips_regfile: 32x32, two asynchronous read ports, one synchronous write port.
REQ-038 ALU and decode SHALL be combinational logic inside multicycle_mips.

Verification
REQ-039 Reset, then addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3=2, IR_addr sequence 0,4,8.
REQ-040 sw r1,8(r0) with MemValid delayed 3 cycles -> A=2, Data2Mem=5, WEN=0 held 4 cycles; lw r4,8(r0) returns 5 -> r4=5.
REQ-041 beq r1,r1,-1 at PC=0x10 -> next IR_addr=0x10; bne with equal operands -> next IR_addr=0x14.
REQ-042 jal 0x40 at PC=0x20 -> r31=0x24, IR_addr=0x100; then jr r31 -> IR_addr=0x24.
REQ-043 lw at address 0x6 -> trap=1, CEN stays 1; MemValid never asserted during sw -> trap=1 after 15 cycles.
REQ-044 Assert rst during MEM with CEN=0 -> CEN=1 without a clock edge, first fetch at RESET_PC.
